uart_host_link: RTL
===================

# uart_host_link

Host-side endpoint of the sensor UART link: it sits on the PC/host-emulation end of the serial line and pairs with a byte-level UART receiver and transmitter. It reassembles the byte stream sent by the sensor board into typed frames (ADS sample, MPR sample, ADS register reply, MPR register reply). It also encodes host commands ('R', 'S', 'a'+addr, 'm'+addr) into the byte sequence the sensor board expects. The receive and command paths are independent and may run concurrently.

## Interface
- TIMEOUT_CLKS, 16'd21700, maximum idle clocks between bytes inside a frame (about 10 byte-times at 115200 baud on 25 MHz).
- i_CLK  in  1  system clock.
- i_RST  in  1  reset, asynchronous, active-high.
- i_RX_BYTE  in  8  byte from the UART receiver.
- i_RX_BYTE_VALID  in  1  one-cycle strobe; i_RX_BYTE is valid in that cycle.
- o_FRAME_DATA  out  56  assembled frame, left-aligned: header in [55:48], unused low bytes are 0.
- o_FRAME_TYPE  out  2  frame type: 0 = ADS data (0xAA), 1 = MPR data (0xBB), 2 = ADS reg (0x61), 3 = MPR reg (0x6D).
- o_FRAME_VALID  out  1  frame held; stays high until accepted.
- i_FRAME_READY  in  1  consumer accepts the frame when i_FRAME_READY and o_FRAME_VALID are both high.
- o_RX_ERROR  out  2  one-cycle error code: 0 = none, 1 = timeout, 2 = overrun.
- o_DROP_COUNT  out  8  count of non-header bytes discarded while hunting; saturates at 255.
- i_CMD  in  16  [15:8] opcode, [7:0] register address.
- i_CMD_VALID  in  1  command request.
- o_CMD_READY  out  1  command path idle.
- o_CMD_ERROR  out  1  one-cycle pulse on an unknown opcode.
- o_TX_BYTE  out  8  byte to the UART transmitter.
- o_TX_BYTE_VALID  out  1  one-cycle strobe that starts the transmitter.
- i_TX_DONE  in  1  one-cycle pulse when the transmitter finishes a byte.

## Operation
- Reset: every output is 0, including o_CMD_READY. The receive FSM enters HUNT and the command FSM enters C_IDLE. o_CMD_READY goes to 1 on the first clock edge after reset is released.
- Receive FSM, HUNT:
  - Each valid byte is checked against the headers 0xAA, 0xBB, 0x61 and 0x6D.
  - A header byte loads the shift register, sets the expected length (7 bytes for 0xAA, 3 bytes for the others), sets the byte count to 1 and moves to COLLECT.
  - Any other byte is discarded and o_DROP_COUNT increments, saturating at 255.
- Receive FSM, COLLECT:
  - Each valid byte is written to the next lower byte lane and the byte count increments.
  - Header values received here are treated as data; the FSM does not resynchronise on them.
  - When the count reaches the expected length, the frame completes and the FSM returns to HUNT.
- Inter-byte timer:
  - Runs only in COLLECT and clears on every valid byte.
  - Reaching TIMEOUT_CLKS aborts the frame: o_RX_ERROR = 1 for one cycle, partial data is discarded, the FSM returns to HUNT.
  - If a byte arrives in the same cycle the timer reaches TIMEOUT_CLKS, the byte wins and no timeout occurs.
- Output register:
  - On completion, if o_FRAME_VALID is 0, the data and type are loaded and o_FRAME_VALID is set.
  - On completion, if o_FRAME_VALID is 1 and no handshake occurs in that cycle, the new frame is dropped and o_RX_ERROR = 2. The held frame is unchanged.
  - On completion in the same cycle as a handshake, the new frame loads and o_FRAME_VALID stays 1.
  - o_FRAME_DATA and o_FRAME_TYPE are stable while o_FRAME_VALID is high.
- Command FSM: C_IDLE → C_SEND → C_WAIT → (C_SEND again, or C_IDLE).
  - In C_IDLE, a command is accepted when i_CMD_VALID and o_CMD_READY are both high. The command is latched and o_CMD_READY drops the next cycle.
  - Opcodes 0x52 and 0x53 send 1 byte (the opcode).
  - Opcodes 0x61 and 0x6D send 2 bytes: the opcode, then the address.
  - Any other opcode: o_CMD_ERROR pulses, nothing is sent, and o_CMD_READY returns the cycle after acceptance.
  - C_SEND drives o_TX_BYTE and pulses o_TX_BYTE_VALID for one cycle, then moves to C_WAIT.
  - C_WAIT holds until i_TX_DONE, then either sends the next byte or returns to C_IDLE.
  - i_TX_DONE received outside C_WAIT is ignored.
- Reset asserted mid-frame or mid-command aborts immediately. The partial frame is lost and no byte strobe is emitted.

## Timing
- o_FRAME_VALID rises in the cycle after the strobe of the last byte.
- A handshake clears o_FRAME_VALID at the next edge, so back-to-back frames are accepted at 1 per cycle at most.
- Timeout fires exactly TIMEOUT_CLKS cycles after the last byte strobe.
- Command path:
  - The first o_TX_BYTE_VALID comes 1 cycle after acceptance.
  - The second byte strobe comes 1 cycle after the first i_TX_DONE.
  - o_CMD_READY rises 1 cycle after the final i_TX_DONE.
- o_RX_ERROR, o_CMD_ERROR and o_TX_BYTE_VALID are single-cycle pulses.

## Test plan
- ADS frame: bytes AA 01 02 03 04 05 06, with i_FRAME_READY=0 → o_FRAME_VALID=1, o_FRAME_DATA=0xAA010203040506, o_FRAME_TYPE=0, and it holds until i_FRAME_READY is driven to 1.
- Garbage then MPR: bytes 11 22 BB 7F 80 → o_DROP_COUNT=2, frame 0xBB7F8000000000, type 1.
- Timeout: AA 01, then no bytes for TIMEOUT_CLKS cycles → o_RX_ERROR=1 pulse, no frame. A following 6D 12 34 gives frame 0x6D123400000000, type 3.
- Overrun: two back-to-back 0x61 frames with i_FRAME_READY=0 → first frame kept, o_RX_ERROR=2 on the second completion.
- Command 0x6105: TX sequence 61, then 05 one cycle after the first i_TX_DONE; o_CMD_READY rises 1 cycle after the second i_TX_DONE. Command 0x5200 sends the single byte 52.
- Command 0x4100 → o_CMD_ERROR pulse, no o_TX_BYTE_VALID, o_CMD_READY high 2 cycles after i_CMD_VALID. Reset asserted during a 0xAA frame → all outputs return to 0.

Source files
------------

// File: rtl/uart_host_link.sv
// uart_host_link
//   Host-side endpoint of the sensor UART link. There are two independent paths.
//   The receive path turns the byte stream from the sensor board into typed,
//   left-aligned frames held for a ready/valid consumer. The command path turns
//   host commands into the one- or two-byte sequence the sensor board expects.
//
// Ports
//   i_CLK, i_RST        clock; asynchronous active-high reset
//   i_RX_BYTE/_VALID    byte from the UART receiver with its one-cycle strobe
//   o_FRAME_DATA/_TYPE  held frame (header in [55:48]) and its type code
//   o_FRAME_VALID       frame held; cleared by the handshake with i_FRAME_READY
//   o_RX_ERROR          one-cycle pulse: 1 = inter-byte timeout, 2 = overrun
//   o_DROP_COUNT        non-header bytes discarded while hunting (saturating)
//   i_CMD/_VALID        command {opcode, address} and request
//   o_CMD_READY         command path idle
//   o_CMD_ERROR         one-cycle pulse on an unknown opcode
//   o_TX_BYTE/_VALID    byte to the UART transmitter with its start strobe
//   i_TX_DONE           transmitter finished a byte
module uart_host_link #(
    parameter logic [15:0] TIMEOUT_CLKS = 16'd21700
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [7:0]  i_RX_BYTE,
    input  logic        i_RX_BYTE_VALID,
    output logic [55:0] o_FRAME_DATA,
    output logic [1:0]  o_FRAME_TYPE,
    output logic        o_FRAME_VALID,
    input  logic        i_FRAME_READY,
    output logic [1:0]  o_RX_ERROR,
    output logic [7:0]  o_DROP_COUNT,
    input  logic [15:0] i_CMD,
    input  logic        i_CMD_VALID,
    output logic        o_CMD_READY,
    output logic        o_CMD_ERROR,
    output logic [7:0]  o_TX_BYTE,
    output logic        o_TX_BYTE_VALID,
    input  logic        i_TX_DONE
);

    typedef enum logic {HUNT, COLLECT} rx_state_t;
    typedef enum logic [1:0] {C_IDLE, C_SEND, C_WAIT} cmd_state_t;

    // ---------------------------------------------------------------- receive
    rx_state_t   rx_state;
    logic [55:0] shift_reg;
    logic [1:0]  rx_type;
    logic [2:0]  exp_len;
    logic [2:0]  byte_cnt;
    logic [15:0] idle_timer;

    logic        is_header;
    logic [1:0]  hdr_type;
    logic [2:0]  hdr_len;
    logic [5:0]  lane_lsb;
    logic [55:0] frame_next;
    logic        frame_done;
    logic        timeout_hit;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        is_header = 1'b1;
        hdr_type  = 2'd0;
        hdr_len   = 3'd3;
        case (i_RX_BYTE)
            8'hAA:   begin hdr_type = 2'd0; hdr_len = 3'd7; end
            8'hBB:   hdr_type = 2'd1;
            8'h61:   hdr_type = 2'd2;
            8'h6D:   hdr_type = 2'd3;
            default: is_header = 1'b0;
        endcase
    end

    // Byte number n of the frame lands in lane [55-8n -: 8].
    assign lane_lsb = 6'd48 - {byte_cnt, 3'b000};

    always_comb begin
        frame_next                 = shift_reg;
        frame_next[lane_lsb +: 8]  = i_RX_BYTE;
    end

    assign frame_done = (rx_state == COLLECT) && i_RX_BYTE_VALID
                        && ((byte_cnt + 3'd1) == exp_len);

    // idle_timer holds (idle edges seen - 1); the edge that would make it
    // TIMEOUT_CLKS aborts unless a byte arrives in that same cycle.
    assign timeout_hit = (rx_state == COLLECT) && !i_RX_BYTE_VALID
                         && (idle_timer == TIMEOUT_CLKS - 16'd1);

    // NOTE: sequential state uses non-blocking assignments; where two assignments
    // hit the same register in one pass, the later one wins.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            rx_state      <= HUNT;
            shift_reg     <= '0;
            rx_type       <= 2'd0;
            exp_len       <= 3'd0;
            byte_cnt      <= 3'd0;
            idle_timer    <= 16'd0;
            o_FRAME_DATA  <= '0;
            o_FRAME_TYPE  <= 2'd0;
            o_FRAME_VALID <= 1'b0;
            o_RX_ERROR    <= 2'd0;
            o_DROP_COUNT  <= 8'd0;
        end else begin
            o_RX_ERROR <= 2'd0;
            if (o_FRAME_VALID && i_FRAME_READY)
                o_FRAME_VALID <= 1'b0;

            case (rx_state)
                HUNT: begin
                    if (i_RX_BYTE_VALID) begin
                        if (is_header) begin
                            shift_reg  <= {i_RX_BYTE, 48'd0};
                            rx_type    <= hdr_type;
                            exp_len    <= hdr_len;
                            byte_cnt   <= 3'd1;
                            idle_timer <= 16'd0;
                            rx_state   <= COLLECT;
                        end else if (o_DROP_COUNT != 8'hFF) begin
                            o_DROP_COUNT <= o_DROP_COUNT + 8'd1;
                        end
                    end
                end
                COLLECT: begin
                    if (i_RX_BYTE_VALID) begin
                        idle_timer <= 16'd0;
                        if (frame_done) begin
                            rx_state <= HUNT;
                            // A frame accepted in this cycle frees the holding register.
                            if (!o_FRAME_VALID || i_FRAME_READY) begin
                                o_FRAME_DATA  <= frame_next;
                                o_FRAME_TYPE  <= rx_type;
                                o_FRAME_VALID <= 1'b1;
                            end else begin
                                o_RX_ERROR <= 2'd2;
                            end
                        end else begin
                            shift_reg <= frame_next;
                            byte_cnt  <= byte_cnt + 3'd1;
                        end
                    end else if (timeout_hit) begin
                        o_RX_ERROR <= 2'd1;
                        rx_state   <= HUNT;
                    end else begin
                        idle_timer <= idle_timer + 16'd1;
                    end
                end
                default: rx_state <= HUNT;
            endcase
        end
    end

    // ---------------------------------------------------------------- command
    cmd_state_t cmd_state;
    logic [7:0] cmd_addr;
    logic       addr_pending;
    logic       op_known;
    logic       op_two_byte;

    assign op_two_byte = (i_CMD[15:8] == 8'h61) || (i_CMD[15:8] == 8'h6D);
    assign op_known    = op_two_byte || (i_CMD[15:8] == 8'h52) || (i_CMD[15:8] == 8'h53);

    // The opcode strobe is issued on the accepting edge so it is visible while
    // the FSM sits in C_SEND; C_SEND is the strobe cycle.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cmd_state       <= C_IDLE;
            cmd_addr        <= 8'd0;
            addr_pending    <= 1'b0;
            o_CMD_READY     <= 1'b0;
            o_CMD_ERROR     <= 1'b0;
            o_TX_BYTE       <= 8'd0;
            o_TX_BYTE_VALID <= 1'b0;
        end else begin
            o_CMD_ERROR     <= 1'b0;
            o_TX_BYTE_VALID <= 1'b0;
            case (cmd_state)
                C_IDLE: begin
                    if (i_CMD_VALID && o_CMD_READY) begin
                        o_CMD_READY <= 1'b0;
                        if (op_known) begin
                            o_TX_BYTE       <= i_CMD[15:8];
                            o_TX_BYTE_VALID <= 1'b1;
                            cmd_addr        <= i_CMD[7:0];
                            addr_pending    <= op_two_byte;
                            cmd_state       <= C_SEND;
                        end else begin
                            o_CMD_ERROR <= 1'b1;
                        end
                    end else begin
                        o_CMD_READY <= 1'b1;
                    end
                end
                C_SEND: cmd_state <= C_WAIT;
                C_WAIT: begin
                    if (i_TX_DONE) begin
                        if (addr_pending) begin
                            o_TX_BYTE       <= cmd_addr;
                            o_TX_BYTE_VALID <= 1'b1;
                            addr_pending    <= 1'b0;
                            cmd_state       <= C_SEND;
                        end else begin
                            o_CMD_READY <= 1'b1;
                            cmd_state   <= C_IDLE;
                        end
                    end
                end
                default: cmd_state <= C_IDLE;
            endcase
        end
    end

endmodule
